// File: rtl/config_sram_loader.sv
// Config SRAM write initiator: takes one {data, addr} word per valid/ready
// handshake, shifts it MSB-first onto the config chain, then strobes config_set.
module config_sram_loader #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 8,
  parameter int SET_CYCLES = 1,
  parameter int COUNT_BITS = 16
) (
  input  logic                  cclk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_BITS-1:0]  in_addr,
  input  logic [DATA_BITS-1:0]  in_data,
  output logic                  shift_enable,
  output logic                  shift_out,
  output logic                  config_set,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] words_sent
);

  localparam int N  = ADDR_BITS + DATA_BITS;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, SET} state_t;

  state_t                state_q, state_d;
  logic [N-1:0]          shreg_q, shreg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]         set_cnt_q, set_cnt_d;
  logic                  shift_enable_q, shift_enable_d;
  logic                  config_set_q, config_set_d;
  logic                  busy_q, busy_d;
  logic [COUNT_BITS-1:0] words_q, words_d;
  logic                  xfer;

  assign in_ready     = (state_q == IDLE) && !rst;
  assign xfer         = in_valid && in_ready;
  assign shift_enable = shift_enable_q;
  // Zeros are shifted in behind the frame, so the MSB reads 0 in SET and IDLE.
  assign shift_out    = shreg_q[N-1];
  assign config_set   = config_set_q;
  assign busy         = busy_q;
  assign words_sent   = words_q;

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    set_cnt_d      = set_cnt_q;
    shift_enable_d = shift_enable_q;
    config_set_d   = config_set_q;
    busy_d         = busy_q;
    words_d        = words_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d        = SHIFT;
          shreg_d        = {in_data, in_addr};
          bit_cnt_d      = BW'(N - 1);
          shift_enable_d = 1'b1;
          busy_d         = 1'b1;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[N-2:0], 1'b0};
        if (bit_cnt_q == '0) begin
          state_d        = SET;
          shift_enable_d = 1'b0;
          config_set_d   = 1'b1;
          set_cnt_d      = SW'(SET_CYCLES - 1);
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      SET: begin
        if (set_cnt_q == '0) begin
          state_d      = IDLE;
          config_set_d = 1'b0;
          busy_d       = 1'b0;
          words_d      = words_q + 1'b1;
        end else begin
          set_cnt_d = set_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d        = IDLE;
        shift_enable_d = 1'b0;
        config_set_d   = 1'b0;
        busy_d         = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      set_cnt_q      <= '0;
      shift_enable_q <= 1'b0;
      config_set_q   <= 1'b0;
      busy_q         <= 1'b0;
      words_q        <= '0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      set_cnt_q      <= set_cnt_d;
      shift_enable_q <= shift_enable_d;
      config_set_q   <= config_set_d;
      busy_q         <= busy_d;
      words_q        <= words_d;
    end
  end

endmodule

// File: tb/tb_config_sram_loader.sv
// Bench for config_sram_loader: a default instance (A) and a SET_CYCLES=3,
// COUNT_BITS=2 instance (B), checked against a word-level chain model.
module tb_config_sram_loader;

  logic cclk = 1'b0;
  always #5 cclk = ~cclk;

  logic       rst_a, valid_a, ready_a, se_a, so_a, cs_a, busy_a;
  logic [7:0] addr_a, data_a;
  logic [15:0] ws_a;
  logic       rst_b, valid_b, ready_b, se_b, so_b, cs_b, busy_b;
  logic [7:0] addr_b, data_b;
  logic [1:0] ws_b;

  config_sram_loader dut_a (
    .cclk(cclk), .rst(rst_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_addr(addr_a), .in_data(data_a), .shift_enable(se_a), .shift_out(so_a),
    .config_set(cs_a), .busy(busy_a), .words_sent(ws_a)
  );

  config_sram_loader #(.SET_CYCLES(3), .COUNT_BITS(2)) dut_b (
    .cclk(cclk), .rst(rst_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_addr(addr_b), .in_data(data_b), .shift_enable(se_b), .shift_out(so_b),
    .config_set(cs_b), .busy(busy_b), .words_sent(ws_b)
  );

  int checks = 0;
  int failures = 0;
  int sel = 0;
  int cyc = 0;
  int last_xfer = 0;
  int xfer_gap = 0;
  int exp_ws[2] = '{0, 0};

  logic rdy, se, so, cs, bsy;
  int   ws;

  always @(posedge cclk) cyc <= cyc + 1;

  always_comb begin
    rdy = (sel != 0) ? ready_b : ready_a;
    se  = (sel != 0) ? se_b    : se_a;
    so  = (sel != 0) ? so_b    : so_a;
    cs  = (sel != 0) ? cs_b    : cs_a;
    bsy = (sel != 0) ? busy_b  : busy_a;
    ws  = (sel != 0) ? int'(ws_b) : int'(ws_a);
  end

  typedef struct {
    logic [7:0]  ad;
    logic [7:0]  dt;
    logic [15:0] exp_stream;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s sel=%0d got=%0h exp=%0h t=%0t", nm, sel, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] ad, input logic [7:0] dt);
    if (sel == 0) begin
      valid_a = v; addr_a = ad; data_a = dt;
    end else begin
      valid_b = v; addr_b = ad; data_b = dt;
    end
  endtask

  // One full word: handshake, N shift cycles, SET_CYCLES commit cycles, back to IDLE.
  task automatic send(input logic [7:0] ad, input logic [7:0] dt, input logic [15:0] exp);
    int w;
    int sc;
    logic [15:0] got;
    logic ok;
    sc = (sel != 0) ? 3 : 1;
    drive(1'b1, ad, dt);
    w = 0;
    while (rdy !== 1'b1 && w < 50) begin
      @(negedge cclk);
      w++;
    end
    if (w >= 50) begin
      chk("ready_timeout", 32'd0, 32'd1);
      drive(1'b0, ad, dt);
      return;
    end
    @(posedge cclk);
    #1;
    xfer_gap  = cyc - last_xfer;
    last_xfer = cyc;
    drive(1'b0, ~ad, ~dt);
    ok  = 1'b1;
    got = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge cclk);
      if (!(se === 1'b1 && cs === 1'b0 && rdy === 1'b0 && bsy === 1'b1)) ok = 1'b0;
      got = {got[14:0], so};
    end
    chk("shift_ctl", {31'd0, ok}, 32'd1);
    chk("stream", {16'd0, got}, {16'd0, exp});
    ok = 1'b1;
    for (int i = 0; i < sc; i++) begin
      @(negedge cclk);
      if (!(cs === 1'b1 && se === 1'b0 && so === 1'b0 && rdy === 1'b0 && bsy === 1'b1)) ok = 1'b0;
      if (i == 0) begin
        chk("write_address", {24'd0, got[7:0]}, {24'd0, ad});
        chk("write_data", {24'd0, got[15:8]}, {24'd0, dt});
      end
    end
    chk("set_ctl", {31'd0, ok}, 32'd1);
    @(negedge cclk);
    exp_ws[sel] = (exp_ws[sel] + 1) % ((sel != 0) ? 4 : 65536);
    chk("idle_after", {28'd0, cs, se, rdy, bsy}, 32'b0010);
    chk("words_sent", ws, exp_ws[sel]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ad, dt;
    int gap;
    int ws_seq[5] = '{1, 2, 3, 0, 1};

    tbl[0] = '{8'hA5, 8'h3C, 16'h3CA5};
    tbl[1] = '{8'h01, 8'hFF, 16'hFF01};
    tbl[2] = '{8'hFE, 8'h00, 16'h00FE};
    tbl[3] = '{8'h00, 8'h00, 16'h0000};
    tbl[4] = '{8'hFF, 8'hFF, 16'hFFFF};
    tbl[5] = '{8'h80, 8'h01, 16'h0180};

    rst_a = 1'b1; valid_a = 1'b0; addr_a = '0; data_a = '0;
    rst_b = 1'b1; valid_b = 1'b0; addr_b = '0; data_b = '0;
    valid_a = 1'b1;
    repeat (3) @(negedge cclk);
    chk("rst_state_a", {25'd0, ready_a, se_a, so_a, cs_a, busy_a, ws_a != 0, 1'b0}, 32'd0);
    chk("rst_state_b", {27'd0, ready_b, se_b, cs_b, busy_b, ws_b != 0}, 32'd0);
    valid_a = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("ready_after_rst", {30'd0, ready_a, ready_b}, 32'b11);

    sel = 0;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].ad, tbl[i].dt, tbl[i].exp_stream);
      if (i > 0) chk("b2b_gap", xfer_gap, 32'd18);
    end

    for (int i = 0; i < 15; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge cclk);
      ad = 8'($urandom);
      dt = 8'($urandom);
      send(ad, dt, {dt, ad});
    end

    // Reset in the middle of a frame: five bits out, then async reset mid-cycle.
    drive(1'b1, 8'h5A, 8'hC3);
    @(posedge cclk);
    #1;
    drive(1'b0, 8'h00, 8'h00);
    repeat (5) @(negedge cclk);
    #2 rst_a = 1'b1;
    #1;
    chk("rst_mid_shift", {27'd0, se_a, cs_a, busy_a, ready_a, so_a}, 32'd0);
    chk("rst_mid_ws", {16'd0, ws_a}, 32'd0);
    @(negedge cclk);
    rst_a = 1'b0;
    exp_ws[0] = 0;
    #1;
    chk("ready_after_mid_rst", {31'd0, ready_a}, 32'd1);
    send(8'h11, 8'h22, 16'h2211);

    sel = 1;
    for (int i = 0; i < 5; i++) begin
      ad = 8'($urandom);
      dt = 8'($urandom);
      send(ad, dt, {dt, ad});
      chk("ws_wrap", ws, ws_seq[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_sram_loader.md
Name: config_sram_loader

Overview:
- Initiator end of the config SRAM write interface. Accepts one (address, data) word per valid/ready transfer, serialises it MSB-first onto the configuration shift chain, then pulses config_set to commit the write.
- Sits between the bitstream source (boot controller or testbench) and the config SRAM data chain, which is ADDR_BITS of address followed by DATA_BITS of data.
- Transmits on the cclk domain.

Parameters:
- ADDR_BITS, 8, width of the address field; must match the downstream chain.
- DATA_BITS, 8, width of the data field; must match the downstream chain.
- SET_CYCLES, 1, number of cycles config_set is held high per word; must be >= 1.
- COUNT_BITS, 16, width of the words_sent counter.

Ports:
- cclk  input  1  configuration clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source has a word to send.
- in_ready  output  1  loader can accept a word.
- in_addr  input  ADDR_BITS  write address.
- in_data  input  DATA_BITS  write data.
- shift_enable  output  1  drives chain shift_enable.
- shift_out  output  1  serial bit; drives chain shift_in.
- config_set  output  1  commit strobe; drives chain config_set.
- busy  output  1  high in any state except IDLE.
- words_sent  output  COUNT_BITS  count of completed commits.

Behaviour:
- Constant: N = ADDR_BITS + DATA_BITS.
- Frame register: frame = {in_data, in_addr}. Bits go out frame[N-1] first, in_addr[0] last, so data lands in the far (data) segment of the chain.
- Reset (async, any time, including mid-frame):
  - state = IDLE; shift_enable, shift_out, config_set, busy = 0; words_sent = 0; shift and bit counters cleared.
  - Any partial frame is discarded and not retried.
  - in_ready = 0 while rst is high.
- FSM states are IDLE, SHIFT, SET.
- IDLE:
  - in_ready = 1; shift_enable = 0; config_set = 0.
  - A transfer happens when in_valid & in_ready are high at a clock edge.
  - On a transfer: load frame into the shift register, set bit_cnt = N-1, go to SHIFT.
- SHIFT:
  - shift_enable = 1 and shift_out = shreg[N-1], both driven directly from flops (no combinational path from inputs).
  - Each edge: shift left by 1 and decrement bit_cnt.
  - When bit_cnt == 0 at an edge, go to SET.
  - shift_enable is high for exactly N consecutive cycles.
- SET:
  - shift_enable = 0; config_set = 1 for exactly SET_CYCLES cycles (uses set_cnt).
  - shift_out is held at 0.
  - On the last SET edge: words_sent += 1 (wraps modulo 2^COUNT_BITS), go to IDLE.
- Timing:
  - Transfer at edge k: shift_enable high cycles k+1 .. k+N; config_set high cycles k+N+1 .. k+N+SET_CYCLES; in_ready high again from cycle k+N+SET_CYCLES+1.
  - Throughput is one word per N + SET_CYCLES + 1 cycles.
- in_ready = 0 in SHIFT and SET. in_addr and in_data are sampled only at the transfer edge; later changes have no effect.
- shift_enable and config_set are never high in the same cycle.
- busy = (state != IDLE).
- in_valid with no transfer (rst high) is ignored; the source must hold in_valid until it sees in_ready.

Test Plan:
- Basic word (ADDR=DATA=8): addr 0xA5, data 0x3C → shift_out over 16 cycles = 0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1; then config_set high 1 cycle; the downstream chain model shows write_address=0xA5, write_data=0x3C during config_set; words_sent=1.
- Back-to-back: in_valid held with words (0x01,0xFF) then (0xFE,0x00) → second transfer occurs exactly 18 cycles after the first; no overlap of shift_enable and config_set; words_sent=2.
- SET_CYCLES=3: any word → config_set high exactly 3 cycles, in_ready low throughout, words_sent increments once.
- Reset mid-SHIFT: assert rst after 5 shifted bits → shift_enable, config_set, busy drop immediately (async); words_sent=0; after release, a new word 0x11/0x22 is sent cleanly.
- Input stability: change in_addr/in_data during SHIFT → serial stream matches values sampled at the transfer edge.
- Counter wrap: COUNT_BITS=2, send 5 words → words_sent sequence 1,2,3,0,1.
